// File: rtl/mem_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-port arbiter for the shared Mem bus with a fixed access latency.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int LAT        = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        rw0,
    input  logic [23:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        rw1,
    input  logic [23:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        mem_enable,
    output logic        mem_rw,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] C_LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic        r_last;
    logic        w_grant_valid;
    logic        w_grant_port;
    logic        w_sel_rw;
    logic [23:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    always_comb begin
        w_next        = r_state;
        w_grant_valid = 1'b0;
        w_grant_port  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant_valid = 1'b1;
                    w_next        = S_BUSY;
                    // On a tie, round-robin favours the port that did not win last time
                    if (req0 && req1)
                        w_grant_port = FIXED_PRIO ? 1'b0 : ~r_last;
                    else
                        w_grant_port = req1;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0)
                    w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_sel_rw    = w_grant_port ? rw1    : rw0;
    assign w_sel_addr  = w_grant_port ? addr1  : addr0;
    assign w_sel_wdata = w_grant_port ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= 24'd0;
            mem_wdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            if (w_grant_valid) begin
                r_owner    <= w_grant_port;
                r_cnt      <= C_LAT_M1;
                mem_enable <= 1'b1;
                mem_rw     <= w_sel_rw;
                mem_addr   <= w_sel_addr;
                mem_wdata  <= w_sel_wdata;
            end else if (r_state == S_BUSY) begin
                if (r_cnt == 4'd0) begin
                    mem_enable <= 1'b0;
                    r_last     <= r_owner;
                    if (r_owner) ack1 <= 1'b1;
                    else         ack0 <= 1'b1;
                    if (!mem_rw) begin
                        if (r_owner) rdata1 <= mem_rdata;
                        else         rdata0 <= mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed bench for mem_bus_arbiter: three instances (LAT=1 RR, LAT=3 RR, LAT=1 fixed).
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_clr;
    logic        req0 [N];
    logic        rw0  [N];
    logic [23:0] addr0 [N];
    logic [31:0] wdata0 [N];
    logic        req1 [N];
    logic        rw1  [N];
    logic [23:0] addr1 [N];
    logic [31:0] wdata1 [N];
    logic        ack0 [N];
    logic        ack1 [N];
    logic [31:0] rdata0 [N];
    logic [31:0] rdata1 [N];
    logic        mem_enable [N];
    logic        mem_rw [N];
    logic [23:0] mem_addr [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic [31:0] mem [N][16];
    int          mem_cnt [N];
    int          en_cnt [N];
    int          both_ack = 0;
    int          cycle = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    generate
        for (genvar k = 0; k < N; k++) begin : g_dut
            mem_bus_arbiter #(
                .LAT        ((k == 1) ? 3 : 1),
                .FIXED_PRIO (k == 2)
            ) u_dut (
                .clk        (clk),
                .reset_n    (reset_n),
                .req0       (req0[k]),
                .rw0        (rw0[k]),
                .addr0      (addr0[k]),
                .wdata0     (wdata0[k]),
                .ack0       (ack0[k]),
                .rdata0     (rdata0[k]),
                .req1       (req1[k]),
                .rw1        (rw1[k]),
                .addr1      (addr1[k]),
                .wdata1     (wdata1[k]),
                .ack1       (ack1[k]),
                .rdata1     (rdata1[k]),
                .mem_enable (mem_enable[k]),
                .mem_rw     (mem_rw[k]),
                .mem_addr   (mem_addr[k]),
                .mem_wdata  (mem_wdata[k]),
                .mem_rdata  (mem_rdata[k])
            );
            assign mem_rdata[k] = mem[k][mem_addr[k][3:0]];
        end
    endgenerate

    // Memory model commits a write only when a full LAT-cycle access completes
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_clr) begin
                for (int i = 0; i < 16; i++) mem[k][i] <= 32'd0;
                mem_cnt[k] <= 0;
            end else if (mem_enable[k]) begin
                if (mem_cnt[k] + 1 == lat_of(k) && mem_rw[k])
                    mem[k][mem_addr[k][3:0]] <= mem_wdata[k];
                mem_cnt[k] <= mem_cnt[k] + 1;
            end else begin
                mem_cnt[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_enable[k]) en_cnt[k] <= en_cnt[k] + 1;
            if (ack0[k] && ack1[k]) both_ack <= both_ack + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input int p, input logic rw, input logic [23:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0[k] = 1'b1; rw0[k] = rw; addr0[k] = a; wdata0[k] = d;
        end else begin
            req1[k] = 1'b1; rw1[k] = rw; addr1[k] = a; wdata1[k] = d;
        end
    endtask

    task automatic clr_req(input int k, input int p);
        if (p == 0) req0[k] = 1'b0;
        else        req1[k] = 1'b0;
    endtask

    task automatic wait_any(input int k, output int p, output int c);
        int n;
        n = 0;
        p = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack0[k] || ack1[k]) && n < 60);
        if (ack0[k] || ack1[k]) p = ack1[k] ? 1 : 0;
        else check("ack_timeout", 32'd0, 32'd1);
        c = cycle;
    endtask

    task automatic wait_ack(input int k, input int p, output int c);
        int n;
        logic a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            a = (p == 0) ? ack0[k] : ack1[k];
        end while (!a && n < 60);
        if (!a) check("ack_timeout", 32'd0, 32'd1);
        c = cycle;
        clr_req(k, p);
    endtask

    task automatic txn(input int k, input int p, input logic rw, input logic [23:0] a, input logic [31:0] d);
        int t, e0, c;
        @(negedge clk);
        set_req(k, p, rw, a, d);
        t  = cycle;
        e0 = en_cnt[k];
        @(negedge clk);
        check("bus_enable", 32'(mem_enable[k]), 32'd1);
        check("bus_rw", 32'(mem_rw[k]), 32'(rw));
        check("bus_addr", 32'(mem_addr[k]), 32'(a));
        if (rw) check("bus_wdata", mem_wdata[k], d);
        wait_ack(k, p, c);
        check("ack_latency", 32'(c - t), 32'(lat_of(k) + 1));
        check("enable_cycles", 32'(en_cnt[k] - e0), 32'(lat_of(k)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int p, c0, c1, t;
        reset_n = 1'b0;
        mem_clr = 1'b1;
        for (int k = 0; k < N; k++) begin
            req0[k] = 0; rw0[k] = 0; addr0[k] = 0; wdata0[k] = 0;
            req1[k] = 0; rw1[k] = 0; addr1[k] = 0; wdata1[k] = 0;
            en_cnt[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_enable", 32'(mem_enable[k]), 32'd0);
            check("rst_ack", 32'({ack0[k], ack1[k]}), 32'd0);
            check("rst_rdata0", rdata0[k], 32'd0);
            check("rst_addr", 32'(mem_addr[k]), 32'd0);
        end
        mem_clr = 1'b0;
        reset_n = 1'b1;

        // LAT=1 write then read on port 0
        txn(0, 0, 1'b1, 24'd2, 32'd3);
        txn(0, 0, 1'b0, 24'd2, 32'd0);
        check("t1_rdata0", rdata0[0], 32'd3);
        check("t1_rdata1", rdata1[0], 32'd0);

        // Simultaneous requests after reset: port 0 first, port 1 three cycles later
        do_reset();
        set_req(0, 0, 1'b0, 24'd2, 32'd0);
        set_req(0, 1, 1'b1, 24'd5, 32'd6);
        t = cycle;
        wait_ack(0, 0, c0);
        check("t2_ack0_lat", 32'(c0 - t), 32'd2);
        check("t2_ack1_low", 32'(ack1[0]), 32'd0);
        check("t2_rdata0", rdata0[0], 32'd3);
        wait_ack(0, 1, c1);
        check("t2_ack_gap", 32'(c1 - c0), 32'd3);
        txn(0, 0, 1'b0, 24'd5, 32'd0);
        check("t2_read5", rdata0[0], 32'd6);

        // Round-robin with both ports continuously requesting
        do_reset();
        set_req(0, 0, 1'b0, 24'd2, 32'd0);
        set_req(0, 1, 1'b0, 24'd5, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_any(0, p, c0);
            check("t3_rr_order", 32'(p), 32'(i % 2));
            if (i == 3) begin
                clr_req(0, 0);
                clr_req(0, 1);
            end
        end

        // Fixed priority: port 1 only after port 0 drops
        @(negedge clk);
        set_req(2, 0, 1'b0, 24'd1, 32'd0);
        set_req(2, 1, 1'b0, 24'd1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_any(2, p, c0);
            check("t3_fixed_order", 32'(p), 32'd0);
            if (i == 3) clr_req(2, 0);
        end
        wait_any(2, p, c0);
        check("t3_fixed_last", 32'(p), 32'd1);
        clr_req(2, 1);

        // LAT=3 instance
        txn(1, 1, 1'b1, 24'd2, 32'd3);
        txn(1, 0, 1'b1, 24'd5, 32'd6);
        txn(1, 1, 1'b0, 24'd5, 32'd0);
        check("t4_rdata1", rdata1[1], 32'd6);

        // Reset during the second BUSY cycle of a LAT=3 write
        @(negedge clk);
        set_req(1, 0, 1'b1, 24'd2, 32'd9);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_enable", 32'(mem_enable[1]), 32'd0);
        check("t5_rw", 32'(mem_rw[1]), 32'd0);
        check("t5_addr", 32'(mem_addr[1]), 32'd0);
        check("t5_wdata", mem_wdata[1], 32'd0);
        check("t5_rdata1", rdata1[1], 32'd0);
        clr_req(1, 0);
        repeat (3) begin
            @(negedge clk);
            check("t5_no_ack", 32'({ack0[1], ack1[1]}), 32'd0);
        end
        reset_n = 1'b1;
        set_req(1, 0, 1'b0, 24'd2, 32'd0);
        set_req(1, 1, 1'b0, 24'd2, 32'd0);
        wait_any(1, p, c0);
        check("t5_first", 32'(p), 32'd0);
        check("t5_rdata0", rdata0[1], 32'd3);
        clr_req(1, 0);
        wait_ack(1, 1, c1);
        check("t5_rdata1_after", rdata1[1], 32'd3);

        // Collision right after reset: port 0 write lands before port 1 read
        do_reset();
        set_req(0, 1, 1'b0, 24'd5, 32'd0);
        set_req(0, 0, 1'b1, 24'd5, 32'd7);
        wait_any(0, p, c0);
        check("t6_first", 32'(p), 32'd0);
        clr_req(0, 0);
        wait_any(0, p, c0);
        check("t6_second", 32'(p), 32'd1);
        clr_req(0, 1);
        check("t6_rdata1", rdata1[0], 32'd7);

        repeat (2) @(negedge clk);
        check("ack_exclusive", 32'(both_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
